// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key-report signals of the 4x4 keypad scanner.
// The scanner uses the master view; the keypad and control logic use the slave view.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner.
// Drives one column low at a time and reports debounced presses as {row,col} codes.
module keypad_scanner #(
    parameter int SCAN_DIVISOR   = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kp
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam int unsigned DIV_W = $clog2(SCAN_DIVISOR);
    localparam int unsigned DC_W  = $clog2(DEBOUNCE_SCANS) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIVISOR - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DEBOUNCE_SCANS);
    localparam logic [DC_W-1:0]  DC_ONE   = DC_W'(1);

    logic [3:0]       r_row_s1, r_row_s2;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_col;
    logic [1:0]       r_col_idx;
    logic [2:0][3:0]  r_samp;
    state_t           r_state, w_state_nxt;
    logic [DC_W-1:0]  r_dcnt, w_dcnt_nxt, w_dcnt_inc;
    logic [3:0]       r_cand, w_cand_nxt;
    logic [3:0]       r_code, w_code_nxt;
    logic             r_held, w_held_nxt;
    logic             r_valid, w_valid_nxt;

    logic             w_tick, w_scan_done;
    logic [15:0]      w_keys;
    logic [4:0]       w_nkeys;
    logic [3:0]       w_key;
    logic             w_none, w_single;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_scan_done = w_tick && (r_col_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1  <= '1;
            r_row_s2  <= '1;
            r_div     <= '0;
            r_col     <= 4'b1110;
            r_col_idx <= '0;
            r_samp    <= '0;
        end else begin
            r_row_s1 <= kp.row;
            r_row_s2 <= r_row_s1;
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                unique case (r_col_idx)
                    2'd0:    r_samp[0] <= ~r_row_s2;
                    2'd1:    r_samp[1] <= ~r_row_s2;
                    2'd2:    r_samp[2] <= ~r_row_s2;
                    default: ;
                endcase
                r_col     <= {r_col[2:0], r_col[3]};
                r_col_idx <= r_col_idx + 2'd1;
            end
        end
    end

    // Column 3 is never stored: it is taken live on the completing tick.
    always_comb begin
        w_keys  = '0;
        w_nkeys = '0;
        w_key   = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                w_keys[r*4 + c] = r_samp[c][r];
            end
            w_keys[r*4 + 3] = ~r_row_s2[r];
        end
        for (int unsigned i = 0; i < 16; i++) begin
            if (w_keys[i]) begin
                w_nkeys = w_nkeys + 1'b1;
                w_key   = 4'(i);
            end
        end
    end

    assign w_none     = (w_nkeys == 5'd0);
    assign w_single   = (w_nkeys == 5'd1);
    assign w_dcnt_inc = r_dcnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
            r_cand  <= '0;
            r_code  <= '0;
            r_held  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_cand  <= w_cand_nxt;
            r_code  <= w_code_nxt;
            r_held  <= w_held_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_cand_nxt  = r_cand;
        w_code_nxt  = r_code;
        w_held_nxt  = r_held;
        w_valid_nxt = 1'b0;
        if (w_scan_done) begin
            unique case (r_state)
                IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_key;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_state_nxt = PRESSED;
                            w_dcnt_nxt  = '0;
                            w_code_nxt  = w_key;
                            w_held_nxt  = 1'b1;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = DEBOUNCE;
                            w_dcnt_nxt  = DC_ONE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_single && (w_key == r_cand)) begin
                        if (w_dcnt_inc == DC_LAST) begin
                            w_state_nxt = PRESSED;
                            w_dcnt_nxt  = '0;
                            w_code_nxt  = r_cand;
                            w_held_nxt  = 1'b1;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_dcnt_nxt = w_dcnt_inc;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_dcnt_nxt  = '0;
                    end
                end
                PRESSED: begin
                    if (w_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            w_state_nxt = IDLE;
                            w_dcnt_nxt  = '0;
                            w_held_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = RELEASE;
                            w_dcnt_nxt  = DC_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (w_none) begin
                        if (w_dcnt_inc == DC_LAST) begin
                            w_state_nxt = IDLE;
                            w_dcnt_nxt  = '0;
                            w_held_nxt  = 1'b0;
                        end else begin
                            w_dcnt_nxt = w_dcnt_inc;
                        end
                    end else begin
                        w_state_nxt = PRESSED;
                        w_dcnt_nxt  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign kp.col       = r_col;
    assign kp.key_code  = r_code;
    assign kp.key_valid = r_valid;
    assign kp.key_held  = r_held;
endmodule
